prog_load_check: RTL

Hardware program loader and result checker wrapping the risc_v core for self-checking regression runs. It writes an instruction stream into instruction memory as 16-bit halfwords, mixing 32-bit and compressed instructions. It pads the remainder with NOPs, plants a terminal self-loop, holds the core in reset during loading, and runs the core for a fixed cycle budget. It then reads back register-file and data-memory words and compares them against an expected stream. It replaces the fixed-size, time-based bench flow with a parametrised, cycle-exact synthesizable sequence.

---
 rtl/prog_load_check_if.sv | 50 +++++
 rtl/prog_load_check.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_check_if.sv
// Loader/checker bus bundle: instruction stream, imem write port, readback port, expected-word stream.
interface prog_load_check_if #(
  parameter int INSTR_HALFWORDS = 64,
  parameter int CPU_DATA_WIDTH  = 32,
  parameter int CHECK_ENTRIES   = 96
);
  localparam int AW = $clog2(INSTR_HALFWORDS);
  localparam int IW = $clog2(CHECK_ENTRIES);

  logic                      ld_valid;
  logic                      ld_ready;
  logic [31:0]               ld_data;
  logic                      ld_compressed;
  logic                      ld_last;

  logic                      imem_we;
  logic [AW-1:0]             imem_addr;
  logic [15:0]               imem_wdata;

  logic                      chk_req;
  logic [IW-1:0]             chk_idx;
  logic [CPU_DATA_WIDTH-1:0] chk_rdata;

  logic                      exp_valid;
  logic                      exp_ready;
  logic [CPU_DATA_WIDTH-1:0] exp_data;
  logic [CPU_DATA_WIDTH-1:0] exp_mask;

  // loader side
  modport slave (
    input  ld_valid, ld_data, ld_compressed, ld_last,
    output ld_ready,
    output imem_we, imem_addr, imem_wdata,
    output chk_req, chk_idx,
    input  chk_rdata,
    input  exp_valid, exp_data, exp_mask,
    output exp_ready
  );

  // environment side: stream sources, imem, core readback
  modport master (
    output ld_valid, ld_data, ld_compressed, ld_last,
    input  ld_ready,
    input  imem_we, imem_addr, imem_wdata,
    input  chk_req, chk_idx,
    output chk_rdata,
    output exp_valid, exp_data, exp_mask,
    input  exp_ready
  );
endinterface

// File: rtl/prog_load_check.sv
// Program loader + result checker around the core: load/pad/loop imem, run, read back and compare.
// Optional CHECK_MASK_EN: compare only bits where exp_mask=1; otherwise exp_mask is ignored.
module prog_load_check #(
  parameter int          INSTR_HALFWORDS = 64,
  parameter int          CPU_DATA_WIDTH  = 32,
  parameter int          CHECK_ENTRIES   = 96,
  parameter int          RUN_CYCLES      = 200,
  parameter logic [31:0] NOOP_PATTERN    = 32'h0000_0013,
  parameter logic [31:0] LOOP_PATTERN    = 32'h0000_0063
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  prog_load_check_if.slave                 bus,
  output logic                             cpu_rst,
  output logic                             done,
  output logic                             pass,
  output logic                             load_overflow,
  output logic [15:0]                      mismatch_count,
  output logic [$clog2(CHECK_ENTRIES)-1:0] first_bad_idx
);
  localparam int AW = $clog2(INSTR_HALFWORDS);
  localparam int IW = $clog2(CHECK_ENTRIES);
  localparam int PW = AW + 1;
  localparam int RW = $clog2(RUN_CYCLES + 1);
  localparam int W  = CPU_DATA_WIDTH;
  localparam logic [PW-1:0] CAP      = PW'(INSTR_HALFWORDS - 2);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CHECK_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PAD, S_LOOP, S_RUN, S_CHECK, S_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] wp;
  logic          hi_pend, last_pend, pair_hi;
  logic [15:0]   hi_data;
  logic [RW-1:0] run_cnt;
  logic [IW-1:0] k;
  logic          issued_all;
  logic          cmp_pend, cmp_last;
  logic [IW-1:0] cmp_idx;
  logic [W-1:0]  exp_q;
  logic [W-1:0]  diff;
  logic          ld_hs, exp_hs, fits, bad;
  logic [15:0]   cnt_nxt;

  assign bus.ld_ready  = (state == S_LOAD) && !hi_pend;
  // a readback is only requested when an expected word is there to pair with it
  assign bus.exp_ready = (state == S_CHECK) && !issued_all && bus.exp_valid;
  assign bus.chk_req   = bus.exp_ready;
  assign bus.chk_idx   = k;

  assign ld_hs  = bus.ld_valid && bus.ld_ready;
  assign exp_hs = bus.exp_ready;
  // once overflowed, every later word is consumed and dropped
  assign fits   = !load_overflow &&
                  (bus.ld_compressed ? (wp + PW'(1) <= CAP) : (wp + PW'(2) <= CAP));

`ifdef CHECK_MASK_EN
  logic [W-1:0] mask_q;
  assign diff = (bus.chk_rdata ^ exp_q) & mask_q;
`else
  assign diff = bus.chk_rdata ^ exp_q;
`endif

  assign bad     = cmp_pend && (|diff);
  assign cnt_nxt = (bad && (mismatch_count != 16'hFFFF)) ? mismatch_count + 16'd1 : mismatch_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      wp             <= '0;
      hi_pend        <= 1'b0;
      last_pend      <= 1'b0;
      pair_hi        <= 1'b0;
      hi_data        <= '0;
      run_cnt        <= '0;
      k              <= '0;
      issued_all     <= 1'b0;
      cmp_pend       <= 1'b0;
      cmp_last       <= 1'b0;
      cmp_idx        <= '0;
      exp_q          <= '0;
`ifdef CHECK_MASK_EN
      mask_q         <= '0;
`endif
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_rst        <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      load_overflow  <= 1'b0;
      mismatch_count <= '0;
      first_bad_idx  <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_LOAD;
            wp             <= '0;
            hi_pend        <= 1'b0;
            last_pend      <= 1'b0;
            pair_hi        <= 1'b0;
            k              <= '0;
            issued_all     <= 1'b0;
            cmp_pend       <= 1'b0;
            cpu_rst        <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            load_overflow  <= 1'b0;
            mismatch_count <= '0;
            first_bad_idx  <= '0;
          end
        end

        S_LOAD: begin
          if (hi_pend) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= wp[AW-1:0];
            bus.imem_wdata <= hi_data;
            wp             <= wp + PW'(1);
            hi_pend        <= 1'b0;
            if (last_pend) state <= S_PAD;
          end else if (ld_hs) begin
            if (fits) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= wp[AW-1:0];
              bus.imem_wdata <= bus.ld_data[15:0];
              wp             <= wp + PW'(1);
              if (!bus.ld_compressed) begin
                hi_pend   <= 1'b1;
                hi_data   <= bus.ld_data[31:16];
                last_pend <= bus.ld_last;
              end else if (bus.ld_last) begin
                state <= S_PAD;
              end
            end else begin
              load_overflow <= 1'b1;
              if (bus.ld_last) state <= S_PAD;
            end
          end
        end

        S_PAD: begin
          if (pair_hi) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= wp[AW-1:0];
            bus.imem_wdata <= NOOP_PATTERN[31:16];
            wp             <= wp + PW'(1);
            pair_hi        <= 1'b0;
          end else if (wp[0]) begin
            // realign to a word boundary with a C.NOP
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= wp[AW-1:0];
            bus.imem_wdata <= 16'h0001;
            wp             <= wp + PW'(1);
          end else if (wp < CAP) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= wp[AW-1:0];
            bus.imem_wdata <= NOOP_PATTERN[15:0];
            wp             <= wp + PW'(1);
            pair_hi        <= 1'b1;
          end else begin
            state <= S_LOOP;
          end
        end

        S_LOOP: begin
          bus.imem_we   <= 1'b1;
          bus.imem_addr <= wp[AW-1:0];
          if (!pair_hi) begin
            bus.imem_wdata <= LOOP_PATTERN[15:0];
            wp             <= wp + PW'(1);
            pair_hi        <= 1'b1;
          end else begin
            bus.imem_wdata <= LOOP_PATTERN[31:16];
            pair_hi        <= 1'b0;
            state          <= S_RUN;
            cpu_rst        <= 1'b1;
            run_cnt        <= '0;
          end
        end

        S_RUN: begin
          if (run_cnt == RUN_LAST) state <= S_CHECK;
          else                     run_cnt <= run_cnt + RW'(1);
        end

        S_CHECK: begin
          cmp_pend <= exp_hs;
          if (exp_hs) begin
            exp_q    <= bus.exp_data;
`ifdef CHECK_MASK_EN
            mask_q   <= bus.exp_mask;
`endif
            cmp_idx  <= k;
            cmp_last <= (k == IDX_LAST);
            if (k == IDX_LAST) issued_all <= 1'b1;
            else               k <= k + IW'(1);
          end
          if (cmp_pend) begin
            mismatch_count <= cnt_nxt;
            if (bad && (mismatch_count == 16'd0)) first_bad_idx <= cmp_idx;
            if (cmp_last) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (cnt_nxt == 16'd0) && !load_overflow;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
